// File: rtl/avm_cmd_arbiter_pkg.sv
// rtl/avm_cmd_arbiter_pkg.sv - shared widths, state encoding and helpers for the AVM command arbiter
package avm_cmd_arbiter_pkg;

    localparam int AVM_WORD_SIZE_WIDTH = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Index width for n ports; a 1-port-wide index is still one bit wide.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/avm_cmd_arbiter_if.sv
// rtl/avm_cmd_arbiter_if.sv - command channel between the arbiter and the avalon_master_fifo
interface avm_cmd_arbiter_if
    import avm_cmd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0]          cmd_addr;
    logic                           cmd_read_enable;
    logic                           cmd_write_enable;
    logic [AVM_WORD_SIZE_WIDTH-1:0] cmd_word_size;
    logic                           cmd_done;

    modport master (
        output cmd_addr,
        output cmd_read_enable,
        output cmd_write_enable,
        output cmd_word_size,
        input  cmd_done
    );

    modport slave (
        input  cmd_addr,
        input  cmd_read_enable,
        input  cmd_write_enable,
        input  cmd_word_size,
        output cmd_done
    );

endinterface

// File: rtl/avm_rr_select.sv
// rtl/avm_rr_select.sv - combinational round-robin picker: first unmasked requester at or after ptr
module avm_rr_select
    import avm_cmd_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = clog2_min1(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_BITS-1:0] ptr,
    input  logic [NUM_PORTS-1:0] mask,
    output logic                 valid,
    output logic [PORT_BITS-1:0] index
);

    logic [NUM_PORTS-1:0] eligible;

    assign eligible = req & ~mask;

    // Scan from farthest to nearest so the port closest to ptr overwrites the rest.
    always_comb begin
        int p;
        valid = 1'b0;
        index = '0;
        p     = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            p = int'(ptr) + k;
            if (p >= NUM_PORTS) begin
                p = p - NUM_PORTS;
            end
            if (eligible[p]) begin
                valid = 1'b1;
                index = PORT_BITS'(p);
            end
        end
    end

endmodule

// File: rtl/avm_cmd_arbiter.sv
// rtl/avm_cmd_arbiter.sv - round-robin sharing of one avalon_master_fifo command channel among NUM_PORTS requesters
module avm_cmd_arbiter
    import avm_cmd_arbiter_pkg::*;
#(
    parameter int  NUM_PORTS        = 4,
    parameter int  C_AVM_ADDR_WIDTH = 32,
    localparam int PORT_BITS        = clog2_min1(NUM_PORTS)
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETN,
    input  logic [NUM_PORTS*C_AVM_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]                  req_read,
    input  logic [NUM_PORTS-1:0]                  req_write,
    input  logic [NUM_PORTS*AVM_WORD_SIZE_WIDTH-1:0] req_word_size,
    output logic [NUM_PORTS-1:0]                  req_done,
    avm_cmd_arbiter_if.master                     cmd,
    output logic                                  grant_valid,
    output logic [PORT_BITS-1:0]                  grant_index,
    output logic [NUM_PORTS-1:0]                  grant_onehot
);

    arb_state_t                     state_q, state_d;
    logic [PORT_BITS-1:0]           ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]           mask_q, mask_d;
    logic [NUM_PORTS-1:0]           zdone_q, zdone_d;
    logic [C_AVM_ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [AVM_WORD_SIZE_WIDTH-1:0] size_q, size_d;
    logic                           rd_q, rd_d;
    logic                           wr_q, wr_d;
    logic                           gv_q, gv_d;
    logic [PORT_BITS-1:0]           gi_q, gi_d;
    logic [NUM_PORTS-1:0]           goh_q, goh_d;

    logic [NUM_PORTS-1:0]           req_any;
    logic                           sel_valid;
    logic [PORT_BITS-1:0]           sel_index;
    logic [C_AVM_ADDR_WIDTH-1:0]    port_addr [NUM_PORTS];
    logic [AVM_WORD_SIZE_WIDTH-1:0] port_size [NUM_PORTS];

    function automatic logic [NUM_PORTS-1:0] to_onehot(input logic [PORT_BITS-1:0] idx);
        logic [NUM_PORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [PORT_BITS-1:0] next_port(input logic [PORT_BITS-1:0] idx);
        return (idx == PORT_BITS'(NUM_PORTS - 1)) ? '0 : idx + PORT_BITS'(1);
    endfunction

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign port_addr[p] = req_addr[p*C_AVM_ADDR_WIDTH +: C_AVM_ADDR_WIDTH];
        assign port_size[p] = req_word_size[p*AVM_WORD_SIZE_WIDTH +: AVM_WORD_SIZE_WIDTH];
    end

    assign req_any = req_read | req_write;

    avm_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BITS (PORT_BITS)
    ) u_rr_select (
        .req   (req_any),
        .ptr   (ptr_q),
        .mask  (mask_q),
        .valid (sel_valid),
        .index (sel_index)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mask_d  = '0;
        zdone_d = '0;
        addr_d  = addr_q;
        size_d  = size_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        gv_d    = gv_q;
        gi_d    = gi_q;
        goh_d   = goh_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    // A zero-length read would never complete in the FIFO, so retire it here.
                    if (port_size[sel_index] == '0) begin
                        zdone_d = to_onehot(sel_index);
                        mask_d  = to_onehot(sel_index);
                        ptr_d   = next_port(sel_index);
                    end else begin
                        addr_d  = port_addr[sel_index];
                        size_d  = port_size[sel_index];
                        rd_d    = req_read[sel_index];
                        wr_d    = ~req_read[sel_index] & req_write[sel_index];
                        gv_d    = 1'b1;
                        gi_d    = sel_index;
                        goh_d   = to_onehot(sel_index);
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (cmd.cmd_done) begin
                    addr_d  = '0;
                    size_d  = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    gv_d    = 1'b0;
                    gi_d    = '0;
                    goh_d   = '0;
                    mask_d  = goh_q;
                    ptr_d   = next_port(gi_q);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            mask_q  <= '0;
            zdone_q <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            gv_q    <= 1'b0;
            gi_q    <= '0;
            goh_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            zdone_q <= zdone_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            gv_q    <= gv_d;
            gi_q    <= gi_d;
            goh_q   <= goh_d;
        end
    end

    // Completion is routed back in the done cycle itself.
    always_comb begin
        req_done = zdone_q;
        if (state_q == ST_BUSY && cmd.cmd_done) begin
            req_done = zdone_q | goh_q;
        end
    end

    assign cmd.cmd_addr         = addr_q;
    assign cmd.cmd_word_size    = size_q;
    assign cmd.cmd_read_enable  = rd_q;
    assign cmd.cmd_write_enable = wr_q;
    assign grant_valid          = gv_q;
    assign grant_index          = gi_q;
    assign grant_onehot         = goh_q;

endmodule

// File: tb/tb_avm_cmd_arbiter.sv
// tb/tb_avm_cmd_arbiter.sv - self-checking bench for avm_cmd_arbiter against a transaction-level reference model
module tb_avm_cmd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_read = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*9-1:0]  req_word_size = '0;
    logic [N-1:0]    req_done;
    logic            grant_valid;
    logic [1:0]      grant_index;
    logic [N-1:0]    grant_onehot;

    avm_cmd_arbiter_if #(.ADDR_WIDTH(AW)) cmd_if ();

    avm_cmd_arbiter #(
        .NUM_PORTS        (N),
        .C_AVM_ADDR_WIDTH (AW)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .req_addr      (req_addr),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_word_size (req_word_size),
        .req_done      (req_done),
        .cmd           (cmd_if.master),
        .grant_valid   (grant_valid),
        .grant_index   (grant_index),
        .grant_onehot  (grant_onehot)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester-side command state driven by the bench
    logic [AW-1:0] r_addr [N];
    logic [8:0]    r_size [N];
    bit            r_rd [N];
    bit            r_wr [N];
    int            cool [N];
    bit [N-1:0]    done_seen;
    bit            cmd_done_v;
    int            req_mode;
    int            fixed_delay;
    bit            idle_noise;

    // Reference model: who owns the channel, rotation point, guard port, pending zero-length retire
    int            m_owner, m_ptr, m_mask, m_zero, m_completed;
    logic [AW-1:0] m_addr;
    logic [8:0]    m_size;
    bit            m_rd, m_wr;
    int            own_cnt, done_delay;

    logic [N-1:0]  obs_done;
    logic          obs_rd, obs_wr, obs_gv, prev_gv;
    logic [AW-1:0] obs_addr;
    logic [8:0]    obs_size;
    logic [1:0]    obs_gi;
    int            grant_log[$];
    int            done_pulses;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_port();
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (p != m_mask && (r_rd[p] || r_wr[p])) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_mask = -1; m_zero = -1;
        m_addr = '0; m_size = '0; m_rd = 0; m_wr = 0;
        own_cnt = 0; done_delay = 0; done_seen = '0; prev_gv = 0;
    endtask

    task automatic clear_requests();
        for (int p = 0; p < N; p++) begin
            r_addr[p] = '0; r_size[p] = '0; r_rd[p] = 0; r_wr[p] = 0; cool[p] = 0;
        end
    endtask

    task automatic new_cmd(input int p);
        int d;
        d = $urandom_range(0, 2);
        r_addr[p] = $urandom;
        r_size[p] = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
        r_rd[p]   = (d != 1);
        r_wr[p]   = (d != 0);
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < N; p++) begin
            req_addr[p*AW +: AW]    = r_addr[p];
            req_word_size[p*9 +: 9] = r_size[p];
            req_read[p]             = r_rd[p];
            req_write[p]            = r_wr[p];
        end
        cmd_if.cmd_done = cmd_done_v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gv"},   grant_valid, 0);
        check({tag, "_gi"},   grant_index, 0);
        check({tag, "_goh"},  grant_onehot, 0);
        check({tag, "_rd"},   cmd_if.cmd_read_enable, 0);
        check({tag, "_wr"},   cmd_if.cmd_write_enable, 0);
        check({tag, "_addr"}, cmd_if.cmd_addr, 0);
        check({tag, "_size"}, cmd_if.cmd_word_size, 0);
        check({tag, "_done"}, req_done, 0);
    endtask

    // One clock cycle: requester/FIFO behaviour, compare, advance the model across the edge.
    task automatic step();
        logic [N-1:0] exp_done;
        int pk;
        for (int p = 0; p < N; p++) begin
            if (done_seen[p]) begin
                r_rd[p] = 0; r_wr[p] = 0; cool[p] = $urandom_range(0, 3);
            end else if (req_mode == 1 && !(r_rd[p] || r_wr[p])) begin
                r_wr[p] = 1; r_rd[p] = 0; r_addr[p] = $urandom;
                r_size[p] = 9'($urandom_range(1, 511));
            end else if (req_mode == 2 && !(r_rd[p] || r_wr[p])) begin
                if (cool[p] > 0) cool[p]--;
                else if ($urandom_range(0, 1) == 1) new_cmd(p);
            end
        end
        if (req_mode == 2 && m_owner >= 0 && $urandom_range(0, 2) == 0) begin
            r_addr[m_owner] = $urandom;
            r_size[m_owner] = 9'($urandom);
        end
        if (m_owner >= 0) cmd_done_v = (own_cnt >= done_delay);
        else              cmd_done_v = idle_noise && ($urandom_range(0, 7) == 0);
        drive_inputs();
        #1;
        exp_done = '0;
        if (m_zero >= 0) exp_done[m_zero] = 1'b1;
        if (m_owner >= 0 && cmd_done_v) exp_done[m_owner] = 1'b1;
        check("grant_valid",  grant_valid, m_owner >= 0);
        check("grant_index",  grant_index, (m_owner >= 0) ? m_owner : 0);
        check("grant_onehot", grant_onehot, (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
        check("cmd_addr",     cmd_if.cmd_addr, m_addr);
        check("cmd_size",     cmd_if.cmd_word_size, m_size);
        check("cmd_rd",       cmd_if.cmd_read_enable, m_rd);
        check("cmd_wr",       cmd_if.cmd_write_enable, m_wr);
        check("req_done",     req_done, exp_done);
        obs_done = req_done; obs_rd = cmd_if.cmd_read_enable; obs_wr = cmd_if.cmd_write_enable;
        obs_addr = cmd_if.cmd_addr; obs_size = cmd_if.cmd_word_size;
        obs_gv = grant_valid; obs_gi = grant_index;
        if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_index));
        prev_gv = grant_valid;
        done_pulses += $countones(req_done);
        done_seen = exp_done;
        if (exp_done != '0) m_completed++;
        // Advance the model across the clock edge
        m_zero = -1;
        if (m_owner >= 0) begin
            if (cmd_done_v) begin
                m_ptr = (m_owner + 1) % N; m_mask = m_owner; m_owner = -1;
                m_addr = '0; m_size = '0; m_rd = 0; m_wr = 0;
            end else begin
                m_mask = -1; own_cnt++;
            end
        end else begin
            pk = pick_port();
            m_mask = -1;
            if (pk >= 0) begin
                if (r_size[pk] == 0) begin
                    m_zero = pk; m_mask = pk; m_ptr = (pk + 1) % N;
                end else begin
                    m_owner = pk; m_addr = r_addr[pk]; m_size = r_size[pk];
                    m_rd = r_rd[pk]; m_wr = !r_rd[pk]; own_cnt = 0;
                    done_delay = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 4);
                end
            end
        end
        @(negedge ACLK);
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        clear_requests();
        cmd_done_v = 0;
        drive_inputs();
        @(posedge ACLK);
        #1;
        check_all_zero("reset");
        @(negedge ACLK);
        ARESETN = 1'b1;
        model_reset();
    endtask

    task automatic run_until_done(input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            hit = (obs_done != '0);
        end
    endtask

    initial begin
        int d0, c0;
        req_mode = 0; fixed_delay = 2; idle_noise = 0; done_pulses = 0; m_completed = 0;
        clear_requests();
        model_reset();
        cmd_done_v = 0;
        drive_inputs();
        @(negedge ACLK);
        do_reset();

        // Single read on port 2, FIFO done 10 cycles after the command starts
        fixed_delay = 10;
        r_rd[2] = 1; r_addr[2] = 32'h1000; r_size[2] = 9'd4;
        step();
        step();
        check("t1_rd_en", obs_rd, 1);
        check("t1_addr", obs_addr, 32'h1000);
        check("t1_size", obs_size, 4);
        run_until_done(30);
        check("t1_req_done", obs_done, 4'b0100);
        check("t1_rd_in_done_cycle", obs_rd, 1);
        step();
        check("t1_rd_low_after", obs_rd, 0);

        // All four ports writing continuously, each command completing after 3 cycles
        do_reset();
        req_mode = 1; fixed_delay = 3;
        grant_log.delete();
        d0 = done_pulses; c0 = m_completed;
        repeat (30) step();
        for (int k = 0; k < 5; k++)
            check($sformatf("t2_grant_%0d", k), (k < grant_log.size()) ? grant_log[k] : 99, k % N);
        check("t2_done_count", done_pulses - d0, m_completed - c0);

        // Read and write together: read wins
        do_reset();
        req_mode = 0; fixed_delay = 2;
        r_rd[1] = 1; r_wr[1] = 1; r_size[1] = 9'd8; r_addr[1] = 32'h40;
        step();
        step();
        check("t3_rd_en", obs_rd, 1);
        check("t3_wr_en", obs_wr, 0);
        run_until_done(20);
        step();

        // Zero-length on port 3 retires without reaching the FIFO; port 0 follows
        fixed_delay = 6;
        r_rd[3] = 1; r_size[3] = 9'd0; r_addr[3] = 32'h300;
        r_wr[0] = 1; r_size[0] = 9'd5; r_addr[0] = 32'hA0;
        step();
        step();
        check("t4_zero_done", obs_done, 4'b1000);
        check("t4_no_enable", {obs_rd, obs_wr}, 2'b00);
        step();
        check("t4_gv", obs_gv, 1);
        check("t4_gi", obs_gi, 0);

        // Requester changes its fields while the command is in flight
        r_addr[0] = 32'hDEAD0000; r_size[0] = 9'd77;
        step();
        step();
        check("t5_addr_held", obs_addr, 32'hA0);
        check("t5_size_held", obs_size, 5);
        run_until_done(20);
        step();

        // Asynchronous reset in the middle of a command
        do_reset();
        fixed_delay = 20;
        r_rd[2] = 1; r_addr[2] = 32'h2000; r_size[2] = 9'd3;
        step();
        r_wr[1] = 1; r_addr[1] = 32'h1100; r_size[1] = 9'd2;
        r_wr[3] = 1; r_addr[3] = 32'h3300; r_size[3] = 9'd7;
        step();
        check("t6_busy_before_reset", obs_gv, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(negedge ACLK);
        #1;
        ARESETN = 1'b1;
        model_reset();
        step();
        step();
        check("t6_first_gv", obs_gv, 1);
        check("t6_first_gi", obs_gi, 1);

        // Randomized traffic with spurious idle done pulses
        do_reset();
        req_mode = 2; fixed_delay = -1; idle_noise = 1;
        repeat (1500) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
